fetch_redirect_ctrl: RTL
========================

Name: fetch_redirect_ctrl

Overview:
- Owns the architectural PC and sequences instruction fetch against the instruction memory handshake.
- Applies taken-branch/jump redirects produced by the ID-stage branch unit: target selection, delay-slot preservation, and killing wrong-path instructions.
- Sits between the branch unit, hazard unit, instruction memory and the IF/ID pipeline register.
- Keeps 16-bit performance counters for redirects and killed fetches.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
DELAY_SLOT, 1, 1 = MIPS branch delay slot executes; 0 = no delay slot, sequential instruction is squashed.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall_i  in  1  hazard stall; blocks new fetch and masks br_valid_i.
br_valid_i  in  1  branch unit resolved a control-transfer instruction in ID this cycle.
br_taken_i  in  1  resolved transfer is taken (j/jal/jr always 1).
br_target_i  in  32  redirect target (branch unit newPC).
br_pc_i  in  32  PC of the resolving branch instruction.
imem_req_o  out  1  fetch request.
imem_addr_o  out  32  fetch address (= pc).
imem_ready_i  in  1  memory accepts/returns the request this cycle.
if_valid_o  out  1  accepted instruction is to be written into IF/ID.
if_pc_o  out  32  PC of the accepted instruction.
flush_o  out  1  kill current IF/ID contents (one-cycle pulse).
redirect_cnt_o  out  16  count of applied redirects, wraps.
kill_cnt_o  out  16  count of killed fetches, wraps.

Behaviour:
- Reset (async, any time, including mid-request): pc=RESET_PC, state=BOOT, pend_v=0, disc=0, counters=0. imem_req_o=0, if_valid_o=0, flush_o=0. Any outstanding request is abandoned.
- FSM states:
  - BOOT: one cycle, imem_req_o=0. Goes to RUN.
  - RUN: no pending redirect. Goes to PEND on a deferred redirect.
  - PEND: deferred redirect held in pend_tgt. Returns to RUN on the next accept.
- Outputs:
  - imem_req_o = (state!=BOOT) && !stall_i.
  - imem_addr_o = if_pc_o = pc.
  - accept = imem_req_o && imem_ready_i.
  - if_valid_o = accept && !kill (combinational).
- pc changes only on accept:
  - default pc <= pc+4, modulo 2^32 wrap.
  - If a redirect or pending target applies, pc <= that target.
- Address rule: while imem_req_o=1 and imem_ready_i=0, imem_addr_o stays stable.
- Redirect event R = br_valid_i && br_taken_i && !stall_i. Not-taken or stalled resolutions have no effect. slot = br_pc_i+4.
- Case A, pc==slot (slot is the current request):
  - DELAY_SLOT=1: accept this cycle → slot passes, pc<=br_target_i. No accept → pend_tgt<=target, state PEND, disc=0.
  - DELAY_SLOT=0: accept this cycle → kill, pc<=target. No accept → PEND with disc=1.
- Case B, pc!=slot (slot already in IF/ID; current request is wrong-path):
  - Accept this cycle → kill, pc<=target. No accept → PEND with disc=1.
  - DELAY_SLOT=0 additionally asserts flush_o in the R cycle.
- PEND on accept: pc<=pend_tgt. If disc=1, kill this accept and clear disc. Go to RUN.
- R while already in PEND (illegal stream, defensive): newer target overwrites pend_tgt; disc becomes OR of old and new.
- Counters:
  - redirect_cnt increments on every R (including a PEND overwrite).
  - kill_cnt increments on every killed accept.
  - Both wrap 16'hFFFF → 0.
- flush_o is 0 except the case-B pulse. A kill is never signalled through flush_o; it is only if_valid_o=0.

Test Plan:
- Reset, RESET_PC=0x3000, ready=1 constant, no branches → req first asserted cycle 2; if_pc_o 0x3000, 0x3004, 0x3008… one per cycle, if_valid_o=1.
- DELAY_SLOT=1, ready=1. R with br_pc=0x3000, target=0x3100 while pc=0x3004 (case A) → 0x3004 delivered valid, next fetch 0x3100, redirect_cnt=1, kill_cnt=0.
- DELAY_SLOT=0, case B: br_pc=0x3000, pc=0x3008, target=0x3200, ready=1 → flush_o=1 that cycle, 0x3008 accept has if_valid_o=0, next addr 0x3200, kill_cnt=1.
- DELAY_SLOT=1, case B with ready=0 for 3 cycles → addr holds 0x3008 throughout, then accept killed, pc→target, state RUN.
- stall_i=1 with br_valid_i=1, br_taken_i=1 → req=0, pc unchanged, counters unchanged. After release, fetch resumes at same pc.
- rst_n low mid-PEND, pend_tgt=0x4000 → next fetch after release is 0x3000; 0x4000 never issued; counters 0.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: walks the PC against the imem handshake and applies
// taken-branch redirects from ID, including delay-slot handling and wrong-path kills.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic [31:0] br_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic        flush_o,
    output logic [15:0] redirect_cnt_o,
    output logic [15:0] kill_cnt_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pend_tgt, pend_tgt_next;
    logic        disc, disc_next;
    logic [15:0] redirect_cnt, kill_cnt;

    logic        req, accept, redirect, slot_is_req, wrong, kill;
    logic [31:0] slot, eff_tgt;
    logic        eff_disc;

    always_comb begin
        req         = (state != BOOT) && !stall_i;
        accept      = req && imem_ready_i;
        redirect    = br_valid_i && br_taken_i && !stall_i;
        slot        = br_pc_i + 32'd4;
        slot_is_req = (pc == slot);
        // Instruction at pc is wrong-path unless it is the slot and the slot executes.
        wrong       = slot_is_req ? !DELAY_SLOT : 1'b1;
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        pend_tgt_next = pend_tgt;
        disc_next     = disc;
        kill          = 1'b0;
        eff_tgt       = pend_tgt;
        eff_disc      = disc;
        case (state)
            BOOT: begin
                state_next = RUN;
                if (redirect) begin
                    state_next    = PEND;
                    pend_tgt_next = br_target_i;
                    disc_next     = wrong;
                end
            end
            RUN: begin
                if (redirect) begin
                    if (accept) begin
                        pc_next = br_target_i;
                        kill    = wrong;
                    end else begin
                        state_next    = PEND;
                        pend_tgt_next = br_target_i;
                        disc_next     = wrong;
                    end
                end else if (accept) begin
                    pc_next = pc + 32'd4;
                end
            end
            PEND: begin
                // A second redirect while pending replaces the target; discard is sticky.
                if (redirect) begin
                    eff_tgt  = br_target_i;
                    eff_disc = disc | wrong;
                end
                if (accept) begin
                    pc_next    = eff_tgt;
                    kill       = eff_disc;
                    disc_next  = 1'b0;
                    state_next = RUN;
                end else begin
                    pend_tgt_next = eff_tgt;
                    disc_next     = eff_disc;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            pend_tgt     <= 32'd0;
            disc         <= 1'b0;
            redirect_cnt <= 16'd0;
            kill_cnt     <= 16'd0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            pend_tgt <= pend_tgt_next;
            disc     <= disc_next;
            if (redirect)
                redirect_cnt <= redirect_cnt + 16'd1;
            if (accept && kill)
                kill_cnt <= kill_cnt + 16'd1;
        end
    end

    assign imem_req_o     = req;
    assign imem_addr_o    = pc;
    assign if_pc_o        = pc;
    assign if_valid_o     = accept && !kill;
    assign flush_o        = redirect && !slot_is_req && !DELAY_SLOT;
    assign redirect_cnt_o = redirect_cnt;
    assign kill_cnt_o     = kill_cnt;

endmodule
